// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants for the memory stage of the ARM pipeline.
//   - Register-file index and address widths.
//   - Data memory defaults: base address, depth, wait states.
//   - Memory-stage FSM state encodings.
package mem_stage_pkg;

  localparam int REGISTER_FILE_LEN = 4;
  localparam int ADDRESS_LEN       = 32;

  localparam int MEM_BASE_ADDR   = 1024;
  localparam int MEM_DEPTH       = 64;
  localparam int MEM_WAIT_CYCLES = 2;

  localparam int MEM_STATE_LEN = 2;

  typedef enum logic [MEM_STATE_LEN-1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_data_memory.sv
// mem_stage_data_memory: word-addressed data memory used by mem_stage.
//   clk      in  pipeline clock
//   we       in  write strobe; the write happens only when addr is in range
//   addr     in  byte address (BASE_ADDR maps to word 0, addr[1:0] unused for indexing)
//   wdata    in  store data
//   rdata    out combinational read of the addressed word
//   in_range out BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH
// Contents are never reset.
module mem_stage_data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = MEM_DEPTH,
  parameter int BASE_ADDR = MEM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDRESS_LEN-1:0] addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   in_range
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]            mem [DEPTH];
  logic [ADDRESS_LEN-1:0] off;
  logic [IDX_W-1:0]       idx;

  // Addresses below BASE_ADDR wrap to large unsigned offsets, so a single
  // unsigned compare covers both ends of the window.
  assign off      = addr - ADDRESS_LEN'(BASE_ADDR);
  assign in_range = off < ADDRESS_LEN'(4 * DEPTH);
  assign idx      = off[IDX_W+1:2];
  assign rdata    = mem[idx];

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage ARM pipeline.
//   Performs LDR/STR accesses with WAIT_CYCLES wait states, stalls the
//   pipeline through freeze during an access, and owns the MEM/WB register.
// Ports:
//   clk, rst (async, active-low)
//   wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, alu_res_in, val_r_m_in  from EXE/MEM
//   freeze                                              combinational stall
//   wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out  MEM/WB register
//   mem_fault (only with MEM_MISALIGN_FAULT_EN)         misaligned-access flag
// Optional feature: define MEM_MISALIGN_FAULT_EN to flag accesses with
// addr[1:0] != 0, suppressing the store and returning 0 for the load.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int DEPTH       = MEM_DEPTH,
  parameter int BASE_ADDR   = MEM_BASE_ADDR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_en_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic [REGISTER_FILE_LEN-1:0] dest_in,
  input  logic [ADDRESS_LEN-1:0]       alu_res_in,
  input  logic [31:0]                  val_r_m_in,
  output logic                         freeze,
  output logic                         wb_en_out,
  output logic                         mem_r_en_out,
  output logic [REGISTER_FILE_LEN-1:0] dest_out,
  output logic [ADDRESS_LEN-1:0]       alu_res_out,
`ifdef MEM_MISALIGN_FAULT_EN
  output logic                         mem_fault,
`endif
  output logic [31:0]                  mem_data_out
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req;
  logic        misalign;
  logic        we;
  logic        pass_en;
  logic        done_en;
  logic        in_range;
  logic [31:0] rdata;
  logic [31:0] ld_data;

  logic                         wb_en_p0;
  logic                         mem_r_en_p0;
  logic [REGISTER_FILE_LEN-1:0] dest_p0;
  logic [ADDRESS_LEN-1:0]       alu_res_p0;
  logic [31:0]                  mem_data_p0;

  assign req = mem_r_en_in | mem_w_en_in;

`ifdef MEM_MISALIGN_FAULT_EN
  assign misalign = |alu_res_in[1:0];
`else
  assign misalign = 1'b0;
`endif

  mem_stage_data_memory #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_dmem (
    .clk      (clk),
    .we       (we),
    .addr     (alu_res_in),
    .wdata    (val_r_m_in),
    .rdata    (rdata),
    .in_range (in_range)
  );

  // A combined read+write is a store, so it reads back 0; so do
  // out-of-range and faulting accesses.
  assign ld_data = (mem_w_en_in || misalign || !in_range) ? 32'd0 : rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEM_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = MEM_DONE;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
          state_d = MEM_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Upstream is frozen until DONE, so the request inputs are still the
  // original instruction when the write and the MEM/WB load happen.
  always_comb begin
    freeze  = 1'b0;
    we      = 1'b0;
    pass_en = 1'b0;
    done_en = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        freeze  = req;
        pass_en = !req;
      end
      MEM_WAIT: freeze = 1'b1;
      MEM_DONE: begin
        done_en = 1'b1;
        we      = mem_w_en_in && !misalign;
      end
      default: ;
    endcase
  end

  // MEM/WB register (_p0): holds while frozen, never bubbled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_p0    <= 1'b0;
      mem_r_en_p0 <= 1'b0;
      dest_p0     <= '0;
      alu_res_p0  <= '0;
      mem_data_p0 <= '0;
    end else begin
      if (pass_en || done_en) begin
        wb_en_p0    <= wb_en_in;
        mem_r_en_p0 <= mem_r_en_in;
        dest_p0     <= dest_in;
        alu_res_p0  <= alu_res_in;
      end
      if (done_en && mem_r_en_in) begin
        mem_data_p0 <= ld_data;
      end
    end
  end

`ifdef MEM_MISALIGN_FAULT_EN
  logic fault_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_p0 <= 1'b0;
    end else if (pass_en || done_en) begin
      fault_p0 <= done_en && misalign;
    end
  end

  assign mem_fault = fault_p0;
`endif

  assign wb_en_out    = wb_en_p0;
  assign mem_r_en_out = mem_r_en_p0;
  assign dest_out     = dest_p0;
  assign alu_res_out  = alu_res_p0;
  assign mem_data_out = mem_data_p0;

endmodule
